emu_run_ctrl: RTL

EMU_RUN_CTRL -- requirements
Module: emu_run_ctrl

---
 rtl/emu_run_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/emu_run_ctrl.sv
// Emulation run controller: turns start/pause/step/stop commands, the
// end-of-run time and an optional time breakpoint into a registered
// enable for the system clock gate, and counts the enabled cycles.
module emu_run_ctrl #(
  parameter int TIME_WIDTH = 32,
  parameter int STEP_WIDTH = 16,
  parameter int CYC_WIDTH  = 32
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic                  cmd_start,
  input  logic                  cmd_pause,
  input  logic                  cmd_step,
  input  logic                  cmd_stop,
  input  logic [STEP_WIDTH-1:0] step_count,
  input  logic [TIME_WIDTH-1:0] time_curr,
  input  logic [TIME_WIDTH-1:0] time_stop,
  input  logic                  break_en,
  input  logic [TIME_WIDTH-1:0] break_time,
  output logic                  emu_en,
  output logic [2:0]            state,
  output logic                  break_hit,
  output logic                  sim_done,
  output logic [CYC_WIDTH-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  brk_hit_q, brk_hit_d;
  // Remembers that the current breakpoint already fired, so clearing the
  // visible flag on resume does not immediately re-trigger it.
  logic                  brk_seen_q, brk_seen_d;
  logic                  en_q;
  logic                  done_q;
  logic [CYC_WIDTH-1:0]  cyc_q;

  logic time_end;
  logic brk_fire;
  logic step_ok;

  // Next-state logic: time end beats breakpoint beats commands; commands
  // resolve stop > pause > step > start.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    brk_hit_d  = brk_hit_q;
    brk_seen_d = brk_seen_q;
    time_end   = (time_curr >= time_stop);
    brk_fire   = break_en && (time_curr >= break_time) && !brk_hit_q && !brk_seen_q;
    step_ok    = cmd_step && (step_count != '0);

    // Re-arm once the breakpoint is disabled or moved ahead of current time.
    if (!break_en || (time_curr < break_time)) begin
      brk_seen_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_stop) begin
          state_d = DONE;
        end else if (step_ok) begin
          state_d   = STEP;
          step_d    = step_count;
          brk_hit_d = 1'b0;
        end else if (cmd_start) begin
          state_d   = RUN;
          brk_hit_d = 1'b0;
        end
      end
      RUN: begin
        if (time_end) begin
          state_d = DONE;
        end else if (brk_fire) begin
          state_d    = PAUSE;
          brk_hit_d  = 1'b1;
          brk_seen_d = 1'b1;
        end else if (cmd_stop) begin
          state_d = DONE;
        end else if (cmd_pause) begin
          state_d = PAUSE;
        end
      end
      STEP: begin
        if (step_q != '0) begin
          step_d = step_q - STEP_WIDTH'(1);
        end
        if (time_end) begin
          state_d = DONE;
        end else if (brk_fire) begin
          state_d    = PAUSE;
          brk_hit_d  = 1'b1;
          brk_seen_d = 1'b1;
        end else if (cmd_stop) begin
          state_d = DONE;
        end else if (cmd_pause) begin
          state_d = PAUSE;
        end else if (step_q <= STEP_WIDTH'(1)) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (cmd_stop) begin
          state_d = DONE;
        end else if (step_ok) begin
          state_d   = STEP;
          step_d    = step_count;
          brk_hit_d = 1'b0;
        end else if (cmd_start) begin
          state_d   = RUN;
          brk_hit_d = 1'b0;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, flags, registered enable and saturating enabled-cycle counter.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      brk_hit_q  <= 1'b0;
      brk_seen_q <= 1'b0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      brk_hit_q  <= brk_hit_d;
      brk_seen_q <= brk_seen_d;
      en_q       <= (state_d == RUN) || (state_d == STEP);
      done_q     <= (state_d == DONE);
      if (en_q && (cyc_q != '1)) begin
        cyc_q <= cyc_q + CYC_WIDTH'(1);
      end
    end
  end

  assign emu_en      = en_q;
  assign state       = state_q;
  assign break_hit   = brk_hit_q;
  assign sim_done    = done_q;
  assign cycle_count = cyc_q;

endmodule
